// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/shift/rotate/load/clear plus multi-cycle sequences.
// Define UNIV_SHIFT_REG_ARITH_EN to make mode 111 an arithmetic shift right.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROTL = 3'b011;
   localparam logic [2:0] M_ROTR = 3'b100;
   localparam logic [2:0] M_LOAD = 3'b101;
   localparam logic [2:0] M_CLR  = 3'b110;
   localparam logic [2:0] M_ASR  = 3'b111;

   state_t           state, state_nx;
   logic [WIDTH-1:0] q_r, q_nx;
   logic [AMT_W-1:0] rem, rem_nx;
   logic [2:0]       lmode, lmode_nx;
   logic             done_r, done_nx;
   logic [2:0]       eff;
   logic             seq_ok;

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       m,
      input logic [WIDTH-1:0] v,
      input logic [WIDTH-1:0] ld,
      input logic             si
   );
      logic [WIDTH-1:0] r;
      r = v;
      unique case (m)
         M_HOLD: r = v;
         M_SHL:  r = {v[WIDTH-2:0], si};
         M_SHR:  r = {si, v[WIDTH-1:1]};
         M_ROTL: r = {v[WIDTH-2:0], v[WIDTH-1]};
         M_ROTR: r = {v[0], v[WIDTH-1:1]};
         M_LOAD: r = ld;
         M_CLR:  r = '0;
`ifdef UNIV_SHIFT_REG_ARITH_EN
         M_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
`else
         M_ASR:  r = v;
`endif
         default: r = v;
      endcase
      return r;
   endfunction

   // Sequences only make sense for modes that move bits.
   always_comb begin
      seq_ok = 1'b0;
      unique case (1'b1)
         (mode == M_SHL),
         (mode == M_SHR),
         (mode == M_ROTL),
         (mode == M_ROTR): seq_ok = 1'b1;
`ifdef UNIV_SHIFT_REG_ARITH_EN
         (mode == M_ASR):  seq_ok = 1'b1;
`endif
         default:          seq_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      q_nx     = q_r;
      rem_nx   = rem;
      lmode_nx = lmode;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (seq_ok && amt != '0) begin
                  lmode_nx = mode;
                  rem_nx   = amt;
                  state_nx = SHIFT;
               end else begin
                  done_nx = 1'b1;
               end
            end else if (en) begin
               q_nx = apply_op(mode, q_r, d, sin);
            end
         end
         SHIFT: begin
            if (en) begin
               q_nx   = apply_op(lmode, q_r, d, sin);
               rem_nx = rem - AMT_W'(1);
               if (rem == AMT_W'(1)) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         q_r    <= '0;
         rem    <= '0;
         lmode  <= M_HOLD;
         done_r <= 1'b0;
      end else begin
         state  <= state_nx;
         q_r    <= q_nx;
         rem    <= rem_nx;
         lmode  <= lmode_nx;
         done_r <= done_nx;
      end
   end

   assign busy = (state == SHIFT);
   assign eff  = busy ? lmode : mode;
   assign sout = (eff == M_SHL || eff == M_ROTL) ? q_r[WIDTH-1] : q_r[0];
   assign q    = q_r;
   assign done = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: vector table, corner sequences, random vs reference model.
// Honours UNIV_SHIFT_REG_ARITH_EN for mode 111 expectations.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       rst, en, sin, start;
   logic [2:0] mode;
   logic [7:0] d;
   logic [3:0] amt;
   logic [7:0] q;
   logic       sout, busy, done;

   int n_run  = 0;
   int n_fail = 0;

   univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .sin(sin), .start(start), .amt(amt), .q(q),
      .sout(sout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] mode;
      logic [7:0] d;
      logic       sin;
      logic [7:0] eq;
      logic       es;
   } vec_t;

   vec_t vec [10];

`ifdef UNIV_SHIFT_REG_ARITH_EN
   localparam bit ARITH = 1'b1;
`else
   localparam bit ARITH = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // reference semantics written as plain arithmetic on an integer
   function automatic int ref_op(input int m, input int v, input int ld, input int si);
      case (m)
         1: return (v * 2 + si) % 256;
         2: return v / 2 + si * 128;
         3: return (v * 2) % 256 + v / 128;
         4: return v / 2 + (v % 2) * 128;
         5: return ld;
         6: return 0;
         7: return ARITH ? (v / 2 + (v >= 128 ? 128 : 0)) : v;
         default: return v;
      endcase
   endfunction

   task automatic load(input logic [7:0] v);
      start = 1'b0; en = 1'b1; mode = 3'b101; d = v;
      tick();
      en = 1'b0;
   endtask

   int mq, mrem, mlm, mdone;
   bit mbusy;
   bit seqok;
   int eff, es;

   initial begin
      vec[0] = '{3'b101, 8'hA5, 1'b0, 8'hA5, 1'b1};
      vec[1] = '{3'b001, 8'h00, 1'b1, 8'h4B, 1'b0};
      vec[2] = '{3'b010, 8'h00, 1'b0, 8'h25, 1'b1};
      vec[3] = '{3'b110, 8'hFF, 1'b1, 8'h00, 1'b0};
      vec[4] = '{3'b101, 8'h81, 1'b0, 8'h81, 1'b1};
      vec[5] = '{3'b011, 8'h00, 1'b0, 8'h03, 1'b0};
      vec[6] = '{3'b100, 8'h00, 1'b0, 8'h81, 1'b1};
      vec[7] = '{3'b000, 8'h55, 1'b1, 8'h81, 1'b1};
      vec[8] = '{3'b101, 8'h90, 1'b0, 8'h90, 1'b0};
`ifdef UNIV_SHIFT_REG_ARITH_EN
      vec[9] = '{3'b111, 8'h00, 1'b1, 8'hC8, 1'b0};
`else
      vec[9] = '{3'b111, 8'h00, 1'b1, 8'h90, 1'b0};
`endif

      rst = 1'b1; en = 1'b1; mode = 3'b101; d = 8'hFF;
      sin = 1'b0; start = 1'b0; amt = '0;
      tick();
      tick();
      chk("rst_q", q, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0; en = 1'b0;
      tick();
      chk("post_rst_q", q, 8'h00);

      foreach (vec[i]) begin
         en = 1'b1; start = 1'b0;
         mode = vec[i].mode; d = vec[i].d; sin = vec[i].sin;
         tick();
         chk($sformatf("vec%0d_q", i), q, vec[i].eq);
         chk($sformatf("vec%0d_sout", i), sout, vec[i].es);
      end

      // rotl sequence amt=3, restart attempt while busy
      load(8'h81);
      en = 1'b1; start = 1'b1; mode = 3'b011; amt = 4'd3;
      tick();
      chk("seq_start_q", q, 8'h81);
      chk("seq_start_busy", busy, 1);
      mode = 3'b101; d = 8'h00; amt = 4'd9;
      tick();
      chk("seq_s1_q", q, 8'h03);
      chk("seq_s1_busy", busy, 1);
      start = 1'b0;
      tick();
      chk("seq_s2_q", q, 8'h06);
      chk("seq_s2_done", done, 0);
      tick();
      chk("seq_s3_q", q, 8'h0C);
      chk("seq_s3_busy", busy, 0);
      chk("seq_s3_done", done, 1);
      en = 1'b0;
      tick();
      chk("seq_done_pulse", done, 0);
      chk("seq_end_q", q, 8'h0C);

      // rotr amt=2 with a two-cycle stall
      load(8'h01);
      en = 1'b1; start = 1'b1; mode = 3'b100; amt = 4'd2;
      tick();
      start = 1'b0;
      tick();
      chk("stall_s1_q", q, 8'h80);
      en = 1'b0;
      tick();
      chk("stall_a_q", q, 8'h80);
      chk("stall_a_busy", busy, 1);
      tick();
      chk("stall_b_q", q, 8'h80);
      chk("stall_b_done", done, 0);
      en = 1'b1;
      tick();
      chk("stall_s2_q", q, 8'h40);
      chk("stall_s2_done", done, 1);
      chk("stall_s2_busy", busy, 0);

      // amt=0 completes immediately
      start = 1'b1; mode = 3'b001; amt = 4'd0;
      tick();
      chk("amt0_q", q, 8'h40);
      chk("amt0_busy", busy, 0);
      chk("amt0_done", done, 1);
      start = 1'b0; en = 1'b0;
      tick();
      chk("amt0_done_clr", done, 0);

      // reset mid-sequence aborts without done
      load(8'h01);
      en = 1'b1; start = 1'b1; mode = 3'b001; amt = 4'd5; sin = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("abort_q", q, 8'h04);
      rst = 1'b1;
      tick();
      chk("abort_rst_q", q, 8'h00);
      chk("abort_rst_busy", busy, 0);
      rst = 1'b0; mode = 3'b000;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("abort_no_done", done, 0);
         chk("abort_idle", busy, 0);
      end

      // random run against the reference model
      rst = 1'b1; start = 1'b0; en = 1'b0;
      tick();
      rst = 1'b0;
      mq = 0; mrem = 0; mlm = 0; mdone = 0; mbusy = 1'b0;
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 40) == 0);
         start = ($urandom_range(0, 6) == 0);
         en    = ($urandom_range(0, 3) != 0);
         mode  = 3'($urandom_range(0, 7));
         d     = 8'($urandom);
         sin   = 1'($urandom);
         amt   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
         #1;
         eff = mbusy ? mlm : int'(mode);
         es  = (eff == 1 || eff == 3) ? mq / 128 : mq % 2;
         chk("rnd_sout", sout, es);
         if (rst) begin
            mq = 0; mrem = 0; mlm = 0; mdone = 0; mbusy = 1'b0;
         end else begin
            mdone = 0;
            if (!mbusy) begin
               seqok = (mode >= 1 && mode <= 4) || (ARITH && mode == 7);
               if (start) begin
                  if (seqok && amt != 0) begin
                     mbusy = 1'b1; mrem = amt; mlm = mode;
                  end else begin
                     mdone = 1;
                  end
               end else if (en) begin
                  mq = ref_op(mode, mq, d, sin);
               end
            end else if (en) begin
               mq = ref_op(mlm, mq, d, sin);
               mrem--;
               if (mrem == 0) begin
                  mbusy = 1'b0; mdone = 1;
               end
            end
         end
         tick();
         chk("rnd_q", q, mq);
         chk("rnd_busy", busy, mbusy);
         chk("rnd_done", done, mdone);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
